div_arbiter: RTL

Round-robin arbiter and sequencer that shares one `div` instance among NREQ requesters. It latches a granted requester's operands, drives the divider's start/ready/done handshake, and returns quotient/remainder on a shared result bus with a per-requester completion pulse. It sits between the measurement/display clients (e.g. frequency-from-period computations such as 1E9/period) and the single sequential divider.

---
 rtl/div_arb_pkg.sv | 33 +++
 rtl/div.sv | 86 ++++++++
 rtl/rr_pick.sv | 42 ++++
 rtl/div_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_arb_pkg
//  Description : Shared types and constants for the divider arbiter:
//                sequencer state encoding and the divide-by-zero quotient
//                constant (all-ones at any operand width).
//  Revision    : 1.0 - initial release
// ============================================================================
package div_arb_pkg;

    // Widest operand the divide-by-zero constant helper can produce.
    localparam int c_MAX_WIDTH = 64;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // All-ones in the low 'width' bits; the caller slices the low bits it needs.
    function automatic logic [c_MAX_WIDTH-1:0] div0_quotient(input int width);
        logic [c_MAX_WIDTH-1:0] w_q;
        w_q = '0;
        for (int i = 0; i < c_MAX_WIDTH; i++) begin
            w_q[i] = (i < width);
        end
        return w_q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module      : div
//  Description : Sequential restoring unsigned divider, one quotient bit per
//                cycle. i_start is accepted while o_ready is high; o_done
//                pulses for one cycle when o_quotient/o_remain are valid.
//  Ports       : i_clk, i_rst            - clock, synchronous active-high reset
//                i_start                 - begin a division
//                i_dividend, i_divisor   - operands, sampled on i_start
//                o_ready                 - idle, can accept i_start
//                o_done                  - one-cycle completion pulse
//                o_quotient, o_remain    - result
//  Revision    : 1.0 - initial release
// ============================================================================
module div #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remain
);

    localparam int c_CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic             r_done;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // Partial remainder shifted left with the next dividend bit; the top bit
    // of the trial difference is set when the subtraction would go negative.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_dvsr};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvsr  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_busy  <= 1'b1;
                r_count <= c_CW'(WIDTH);
                r_quo   <= i_dividend;
                r_rem   <= '0;
                r_dvsr  <= i_divisor;
            end else if (r_busy) begin
                if (!w_diff[WIDTH]) begin
                    r_rem <= w_diff[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                end
                r_count <= r_count - c_CW'(1);
                if (r_count == c_CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_ready    = !r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo;
    assign o_remain   = r_rem;

endmodule
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request bit at or after the pointer, wrapping NREQ-1 -> 0.
//  Ports       : i_req   - request vector
//                i_ptr   - search start index (always < NREQ)
//                o_valid - at least one request is set
//                o_idx   - selected index
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);

    // Scan offsets from farthest to nearest so the nearest hit is the last
    // assignment and therefore wins.
    always_comb begin
        int w_j;
        o_valid = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = IW'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : div_arbiter
//  Description : Round-robin arbiter and sequencer sharing one divider among
//                NREQ requesters. Latches the granted operands, runs the
//                divider handshake and returns the result on a shared bus
//                with a per-requester completion pulse.
//  Ports       : i_clk, i_rst            - clock, synchronous active-high reset
//                i_req                   - per-requester request level
//                i_dividend, i_divisor   - per-requester operands
//                o_ack                   - operands latched (one-cycle pulse)
//                o_done                  - result valid (one-cycle pulse)
//                o_err                   - divisor was zero (with o_done)
//                o_quotient, o_remain    - shared result, held between results
//                o_busy                  - sequencer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IW    = $clog2(NREQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NREQ-1:0]  i_req,
    input  logic [WIDTH-1:0] i_dividend [NREQ],
    input  logic [WIDTH-1:0] i_divisor  [NREQ],
    output logic [NREQ-1:0]  o_ack,
    output logic [NREQ-1:0]  o_done,
    output logic             o_err,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remain,
    output logic             o_busy
);

    localparam logic [c_MAX_WIDTH-1:0] c_DIV0_FULL = div0_quotient(WIDTH);
    localparam logic [WIDTH-1:0]       c_DIV0_Q    = c_DIV0_FULL[WIDTH-1:0];
    localparam logic [NREQ-1:0]        c_ONE       = NREQ'(1);

    arb_state_t       r_state;
    arb_state_t       w_next_state;

    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic             r_div0;
    logic [NREQ-1:0]  r_ack;
    logic [NREQ-1:0]  r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remain;
    logic             r_busy;

    logic             w_pick_valid;
    logic [IW-1:0]    w_pick_idx;
    logic [WIDTH-1:0] w_pick_divisor;
    logic             w_grant;
    logic             w_result_load;
    logic             w_div_start;
    logic             w_div_ready;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_div_r;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    div #(
        .WIDTH (WIDTH)
    ) u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_div_start),
        .i_dividend (r_dividend),
        .i_divisor  (r_divisor),
        .o_ready    (w_div_ready),
        .o_done     (w_div_done),
        .o_quotient (w_div_q),
        .o_remain   (w_div_r)
    );

    assign w_pick_divisor = i_divisor[w_pick_idx];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // RESP is held until the completion pulse has been issued. On the normal
    // path the pulse is already set on entry, so RESP lasts one cycle; on the
    // divide-by-zero path RESP is entered together with o_ack and the pulse
    // follows a cycle later, keeping o_ack and o_done in separate cycles.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next_state = (w_pick_divisor == '0) ? RESP : START;
                end
            end
            START:   w_next_state = WAIT;
            WAIT: begin
                if (w_div_done) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (|r_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_div_start   = (r_state == START);
        w_grant       = (r_state == IDLE) && w_pick_valid && w_div_ready;
        w_result_load = ((r_state == WAIT) && w_div_done) ||
                        ((r_state == RESP) && !(|r_done));
    end

    // ------------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr   <= '0;
            r_idx      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_div0     <= 1'b0;
            r_ack      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_quotient <= '0;
            r_remain   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            r_busy <= (w_next_state != IDLE);

            if (w_grant) begin
                r_idx      <= w_pick_idx;
                r_dividend <= i_dividend[w_pick_idx];
                r_divisor  <= w_pick_divisor;
                r_div0     <= (w_pick_divisor == '0);
                r_ack      <= c_ONE << w_pick_idx;
            end

            if (w_result_load) begin
                r_done     <= c_ONE << r_idx;
                r_err      <= r_div0;
                r_quotient <= r_div0 ? c_DIV0_Q   : w_div_q;
                r_remain   <= r_div0 ? r_dividend : w_div_r;
            end

            if ((r_state == RESP) && (|r_done)) begin
                r_rr_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
            end
        end
    end

    assign o_ack      = r_ack;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_quotient = r_quotient;
    assign o_remain   = r_remain;
    assign o_busy     = r_busy;

endmodule
`default_nettype wire
